// File: rtl/miriscv_fetch_stage.sv
// Fetch stage: PC, in-order request issue, address queue and instruction buffer toward decode.
// Optional MIRISCV_FETCH_BYPASS_EN forwards a response to decode in its rvalid cycle.
module miriscv_fetch_stage #(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h8000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            cu_kill_f_i,
    input  logic            cu_stall_f_i,
    input  logic            cu_force_f_i,
    input  logic [XLEN-1:0] cu_force_pc_i,
    input  logic            d_taken_i,
    input  logic [XLEN-1:0] d_target_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [ILEN-1:0] instr_rdata_i,
    output logic [ILEN-1:0] f_instr_o,
    output logic [XLEN-1:0] f_current_pc_o,
    output logic [XLEN-1:0] f_next_pc_o,
    output logic            f_valid_o
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_outst;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] r_buf_cnt;
    logic [PTR_W-1:0] r_aq_wp;
    logic [PTR_W-1:0] r_aq_rp;
    logic [PTR_W-1:0] r_buf_wp;
    logic [PTR_W-1:0] r_buf_rp;
    logic [XLEN-1:0]  r_aq  [FIFO_DEPTH];
    fetch_entry_t     r_buf [FIFO_DEPTH];

    logic             w_cu_redirect;
    logic             w_d_redirect;
    logic             w_redirect;
    logic             w_resp_keep;
    logic             w_buf_empty;
    logic             w_bypass;
    logic             w_handshake;
    logic             w_grant;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_occ;
    logic [CNT_W-1:0] w_outst_nxt;
    fetch_entry_t     w_head;

    assign w_buf_empty = (r_buf_cnt == '0);
    assign w_resp_keep = instr_rvalid_i & (r_discard == '0);

`ifdef MIRISCV_FETCH_BYPASS_EN
    assign w_bypass = w_resp_keep & w_buf_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head         = w_bypass ? {instr_rdata_i, r_aq[r_aq_rp]} : r_buf[r_buf_rp];
    assign f_valid_o      = ~w_buf_empty | w_bypass;
    assign f_instr_o      = w_head.instr;
    assign f_current_pc_o = w_head.pc;
    assign f_next_pc_o    = w_head.pc + XLEN'(4);

    // A decode-taken branch only counts when decode actually consumes the head.
    assign w_handshake   = f_valid_o & ~cu_stall_f_i;
    assign w_cu_redirect = cu_kill_f_i | cu_force_f_i;
    assign w_d_redirect  = d_taken_i & w_handshake & ~w_cu_redirect;
    assign w_redirect    = w_cu_redirect | w_d_redirect;

    assign w_occ        = {1'b0, r_buf_cnt} + {1'b0, r_outst};
    assign instr_req_o  = arstn_i & (w_occ < DEPTH_EXT) & ~w_redirect;
    assign instr_addr_o = r_pc;
    assign w_grant      = instr_req_o & instr_gnt_i;
    assign w_outst_nxt  = r_outst + CNT_W'(w_grant) - CNT_W'(instr_rvalid_i);

    assign w_push = w_resp_keep & ~w_redirect & ~(w_bypass & w_handshake);
    assign w_pop  = w_handshake & ~w_buf_empty;

    // Every response pops the address queue, so dropped beats retire their PCs too.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_pc      <= BOOT_ADDR;
            r_outst   <= '0;
            r_discard <= '0;
            r_aq_wp   <= '0;
            r_aq_rp   <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_grant) begin
                r_aq_wp <= ptr_inc(r_aq_wp);
            end
            if (instr_rvalid_i) begin
                r_aq_rp <= ptr_inc(r_aq_rp);
            end
            if (w_redirect) begin
                r_discard <= w_outst_nxt;
            end else if (instr_rvalid_i && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
            if (cu_force_f_i) begin
                r_pc <= cu_force_pc_i;
            end else if (w_d_redirect) begin
                r_pc <= d_target_i;
            end else if (w_grant) begin
                r_pc <= r_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_buf_wp  <= '0;
            r_buf_rp  <= '0;
            r_buf_cnt <= '0;
        end else if (w_redirect) begin
            r_buf_wp  <= '0;
            r_buf_rp  <= '0;
            r_buf_cnt <= '0;
        end else begin
            if (w_push) begin
                r_buf_wp <= ptr_inc(r_buf_wp);
            end
            if (w_pop) begin
                r_buf_rp <= ptr_inc(r_buf_rp);
            end
            if (w_push && !w_pop) begin
                r_buf_cnt <= r_buf_cnt + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_buf_cnt <= r_buf_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_aq[r_aq_wp] <= r_pc;
        end
        if (w_push) begin
            r_buf[r_buf_wp] <= {instr_rdata_i, r_aq[r_aq_rp]};
        end
    end

endmodule

// File: tb/tb_miriscv_fetch_stage.sv
// Directed bench for miriscv_fetch_stage with an in-order instruction memory model (rdata = ~addr).
module tb_miriscv_fetch_stage;

    localparam logic [31:0] BOOT = 32'h8000_0000;
`ifdef MIRISCV_FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk_i          = 1'b0;
    logic        arstn_i        = 1'b1;
    logic        cu_kill_f_i    = 1'b0;
    logic        cu_stall_f_i   = 1'b0;
    logic        cu_force_f_i   = 1'b0;
    logic [31:0] cu_force_pc_i  = '0;
    logic        d_taken_i      = 1'b0;
    logic [31:0] d_target_i     = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i    = 1'b1;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i  = '0;
    logic [31:0] f_instr_o;
    logic [31:0] f_current_pc_o;
    logic [31:0] f_next_pc_o;
    logic        f_valid_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_lat = 1;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] grant_log[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_next[$];
    logic [31:0] dl_instr[$];

    miriscv_fetch_stage dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .cu_kill_f_i(cu_kill_f_i), .cu_stall_f_i(cu_stall_f_i),
        .cu_force_f_i(cu_force_f_i), .cu_force_pc_i(cu_force_pc_i),
        .d_taken_i(d_taken_i), .d_target_i(d_target_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i),
        .f_instr_o(f_instr_o), .f_current_pc_o(f_current_pc_o),
        .f_next_pc_o(f_next_pc_o), .f_valid_o(f_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model and decode monitor: sample 1 unit before the edge, drive 1 unit after.
    always begin
        @(negedge clk_i);
        #4;
        if (arstn_i) begin
            if (instr_req_o && instr_gnt_i) begin
                mq_addr.push_back(instr_addr_o);
                mq_due.push_back(cyc + mem_lat);
                grant_log.push_back(instr_addr_o);
            end
            if (instr_rvalid_i && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (f_valid_o && !cu_stall_f_i) begin
                dl_pc.push_back(f_current_pc_o);
                dl_next.push_back(f_next_pc_o);
                dl_instr.push_back(f_instr_o);
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (!arstn_i) begin
            mq_addr.delete();
            mq_due.delete();
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = ~mq_addr[0];
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset(input int lat);
        arstn_i = 1'b0;
        cu_kill_f_i = 0; cu_stall_f_i = 0; cu_force_f_i = 0; d_taken_i = 0;
        instr_gnt_i = 1'b1;
        mem_lat = lat;
        step();
        step();
        grant_log.delete(); dl_pc.delete(); dl_next.delete(); dl_instr.delete();
        arstn_i = 1'b1;
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        step();
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", instr_req_o); end
        tests++; if (f_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", f_valid_o); end
        tests++; if (instr_addr_o !== BOOT) begin fails++; $display("FAIL rst_addr: got %h want %h", instr_addr_o, BOOT); end
        step();
        grant_log.delete(); dl_pc.delete(); dl_next.delete(); dl_instr.delete();
        arstn_i = 1'b1;
        #1;
        tests++; if (instr_req_o !== 1'b1) begin fails++; $display("FAIL rst_first_req: got %b want 1", instr_req_o); end
        step();
        tests++; if (instr_addr_o !== BOOT + 32'd4) begin fails++; $display("FAIL rst_pc_adv: got %h want %h", instr_addr_o, BOOT + 32'd4); end
    endtask

    task automatic test_sequential();
        do_reset(1);
        step();
        tests++;
        if (instr_rvalid_i !== 1'b1 || f_valid_o !== 1'(BYP)) begin
            fails++; $display("FAIL valid_latency: rvalid=%b f_valid=%b want rvalid=1 f_valid=%0d", instr_rvalid_i, f_valid_o, BYP);
        end
        if (BYP == 0) step();
        tests++;
        if (f_valid_o !== 1'b1 || f_current_pc_o !== BOOT) begin
            fails++; $display("FAIL first_head: valid=%b pc=%h want 1 %h", f_valid_o, f_current_pc_o, BOOT);
        end
        repeat (20) step();
        tests++; if (grant_log.size() < 4 || dl_pc.size() < 6) begin fails++; $display("FAIL seq_count: grants=%0d delivered=%0d want >=4 >=6", grant_log.size(), dl_pc.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (grant_log[i] !== BOOT + 32'(4 * i)) begin fails++; $display("FAIL seq_addr[%0d]: got %h want %h", i, grant_log[i], BOOT + 32'(4 * i)); end
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (dl_pc[i] !== BOOT + 32'(4 * i) || dl_next[i] !== BOOT + 32'(4 * i + 4) || dl_instr[i] !== ~(BOOT + 32'(4 * i))) begin
                fails++; $display("FAIL seq_deliv[%0d]: pc=%h next=%h instr=%h want pc=%h", i, dl_pc[i], dl_next[i], dl_instr[i], BOOT + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        int max_occ = 0;
        do_reset(1);
        cu_stall_f_i = 1'b1;
        repeat (10) begin
            step();
            if (grant_log.size() - dl_pc.size() > max_occ) max_occ = grant_log.size() - dl_pc.size();
        end
        tests++; if (max_occ !== 2) begin fails++; $display("FAIL stall_occ: got %0d want 2", max_occ); end
        tests++; if (f_valid_o !== 1'b1 || f_current_pc_o !== BOOT) begin fails++; $display("FAIL stall_head: valid=%b pc=%h want 1 %h", f_valid_o, f_current_pc_o, BOOT); end
        cu_stall_f_i = 1'b0;
        repeat (20) step();
        tests++; if (dl_pc.size() < 8) begin fails++; $display("FAIL stall_count: got %0d want >=8", dl_pc.size()); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (dl_pc[i] !== BOOT + 32'(4 * i)) begin fails++; $display("FAIL stall_order[%0d]: got %h want %h", i, dl_pc[i], BOOT + 32'(4 * i)); end
        end
    endtask

    task automatic test_d_taken();
        bit found = 0;
        int n0;
        do_reset(1);
        for (int i = 0; i < 20 && !found; i++) begin
            if (f_valid_o && f_current_pc_o == BOOT + 32'h8) found = 1;
            else step();
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL dtaken_wait: pc 0x80000008 not seen within 20 cycles");
        end else begin
            d_taken_i = 1'b1; d_target_i = BOOT + 32'h100;
            step();
            d_taken_i = 1'b0;
            tests++; if (instr_addr_o !== BOOT + 32'h100 || f_valid_o !== 1'b0) begin fails++; $display("FAIL dtaken_redir: addr=%h valid=%b want %h 0", instr_addr_o, f_valid_o, BOOT + 32'h100); end
            n0 = dl_pc.size();
            repeat (15) step();
            tests++;
            if (n0 < 1 || dl_pc[n0-1] !== BOOT + 32'h8 || dl_pc[n0] !== BOOT + 32'h100 || dl_pc[n0+1] !== BOOT + 32'h104) begin
                fails++; $display("FAIL dtaken_stream: got %h %h %h want 80000008 80000100 80000104", dl_pc[n0-1], dl_pc[n0], dl_pc[n0+1]);
            end
        end
    endtask

    task automatic test_d_taken_ignored();
        do_reset(1);
        cu_stall_f_i = 1'b1;
        repeat (4) step();
        d_taken_i = 1'b1; d_target_i = BOOT + 32'h400;
        step();
        step();
        d_taken_i = 1'b0;
        tests++; if (instr_addr_o !== BOOT + 32'h8) begin fails++; $display("FAIL dignore_addr: got %h want %h", instr_addr_o, BOOT + 32'h8); end
        cu_stall_f_i = 1'b0;
        repeat (15) step();
        for (int i = 0; i < 4; i++) begin
            tests++; if (dl_pc[i] !== BOOT + 32'(4 * i)) begin fails++; $display("FAIL dignore_order[%0d]: got %h want %h", i, dl_pc[i], BOOT + 32'(4 * i)); end
        end
    endtask

    task automatic test_priority();
        int n0;
        do_reset(1);
        repeat (3) step();
        cu_force_f_i = 1'b1; cu_force_pc_i = 32'h200;
        d_taken_i = 1'b1; d_target_i = 32'h300;
        #1;
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL prio_req: got %b want 0", instr_req_o); end
        step();
        cu_force_f_i = 1'b0; d_taken_i = 1'b0;
        tests++; if (instr_addr_o !== 32'h200) begin fails++; $display("FAIL prio_addr: got %h want 00000200", instr_addr_o); end
        n0 = dl_pc.size();
        repeat (10) step();
        tests++; if (dl_pc[n0] !== 32'h200 || dl_next[n0] !== 32'h204) begin fails++; $display("FAIL prio_deliv: pc=%h next=%h want 00000200 00000204", dl_pc[n0], dl_next[n0]); end
    endtask

    task automatic test_kill();
        do_reset(1);
        cu_stall_f_i = 1'b1;
        repeat (5) step();
        cu_kill_f_i = 1'b1;
        step();
        cu_kill_f_i = 1'b0;
        tests++; if (f_valid_o !== 1'b0 || instr_addr_o !== BOOT + 32'h8) begin fails++; $display("FAIL kill_state: valid=%b addr=%h want 0 %h", f_valid_o, instr_addr_o, BOOT + 32'h8); end
        cu_stall_f_i = 1'b0;
        repeat (10) step();
        tests++; if (dl_pc[0] !== BOOT + 32'h8) begin fails++; $display("FAIL kill_resume: got %h want %h", dl_pc[0], BOOT + 32'h8); end
    endtask

    task automatic test_latency3();
        int  beats = 0;
        bit  seen = 0;
        do_reset(3);
        step();
        step();
        tests++; if (grant_log.size() !== 2 || instr_rvalid_i !== 1'b0) begin fails++; $display("FAIL lat3_outst: grants=%0d rvalid=%b want 2 0", grant_log.size(), instr_rvalid_i); end
        cu_force_f_i = 1'b1; cu_force_pc_i = BOOT + 32'h200;
        step();
        cu_force_f_i = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (f_valid_o) seen = 1;
            else begin
                if (instr_rvalid_i) beats++;
                step();
            end
        end
        tests++; if (!seen || beats != 3 - BYP) begin fails++; $display("FAIL lat3_discard: seen=%0d beats=%0d want 1 %0d", seen, beats, 3 - BYP); end
        tests++; if (f_current_pc_o !== BOOT + 32'h200) begin fails++; $display("FAIL lat3_first: got %h want %h", f_current_pc_o, BOOT + 32'h200); end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        do_reset(1);
        cu_force_f_i = 1'b1; cu_force_pc_i = 32'hFFFF_FFFC;
        step();
        cu_force_f_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (f_valid_o) seen = 1;
            else step();
        end
        tests++;
        if (!seen || f_current_pc_o !== 32'hFFFF_FFFC || f_next_pc_o !== 32'h0 || f_instr_o !== 32'h3) begin
            fails++; $display("FAIL wrap: seen=%0d pc=%h next=%h instr=%h want fffffffc 00000000 00000003", seen, f_current_pc_o, f_next_pc_o, f_instr_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        step();
        step();
        tests++; if (grant_log.size() !== 2) begin fails++; $display("FAIL rmid_outst: got %0d want 2", grant_log.size()); end
        arstn_i = 1'b0;
        #1;
        tests++; if (f_valid_o !== 1'b0 || instr_req_o !== 1'b0) begin fails++; $display("FAIL rmid_inrst: valid=%b req=%b want 0 0", f_valid_o, instr_req_o); end
        step();
        step();
        grant_log.delete(); dl_pc.delete(); dl_next.delete(); dl_instr.delete();
        arstn_i = 1'b1;
        #1;
        tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== BOOT || f_valid_o !== 1'b0) begin fails++; $display("FAIL rmid_release: req=%b addr=%h valid=%b want 1 %h 0", instr_req_o, instr_addr_o, f_valid_o, BOOT); end
        repeat (12) step();
        tests++; if (dl_pc.size() < 1 || dl_pc[0] !== BOOT) begin fails++; $display("FAIL rmid_first: n=%0d pc=%h want %h", dl_pc.size(), dl_pc[0], BOOT); end
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_d_taken();
        test_d_taken_ignored();
        test_priority();
        test_kill();
        test_latency3();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
